// File: rtl/adda_pkg.sv
// Shared constants and helpers for the ADDA decimating offset-binary formatter.
package adda_pkg;

  localparam logic MODE_PICK = 1'b0;
  localparam logic MODE_AVG  = 1'b1;

  localparam int DEF_DATA_WIDTH = 14;
  localparam int DEF_MAX_LOG2   = 4;
  localparam int DEF_DEPTH      = 8;

  localparam int ACC_WIDTH = DEF_DATA_WIDTH + DEF_MAX_LOG2;
  localparam int LVL_WIDTH = $clog2(DEF_DEPTH + 1);

  function automatic int acc_width(int dw, int ml);
    return dw + ml;
  endfunction

  function automatic int lvl_width(int depth);
    return $clog2(depth + 1);
  endfunction

  // Two's complement to offset binary: invert the sign bit of a w-bit value.
  function automatic logic [31:0] to_offset_bin(logic [31:0] x, int w);
    return x ^ (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/adda_sync_fifo.sv
// Single-clock FIFO; a push on a full FIFO is accepted only alongside a pop.
module adda_sync_fifo
  import adda_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wp, r_rp;
  logic [LW-1:0]         r_level;
  logic                  w_push, w_pop;

  assign empty  = (r_level == '0);
  assign full   = (r_level == LW'(DEPTH));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end

  assign dout  = r_mem[r_rp];
  assign level = r_level;

endmodule

// File: rtl/adda_decim_ob.sv
// Power-of-two decimator (pick/average) feeding an offset-binary output FIFO.
// Define ADDA_DS_ROUND_EN for round-half-up averaging instead of floor.
module adda_decim_ob
  import adda_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_LOG2   = DEF_MAX_LOG2,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           dataIn,
  input  logic [$clog2(MAX_LOG2+1)-1:0]   ratio_log2,
  input  logic                            mode,
  output logic [DATA_WIDTH-1:0]           dsoutdata,
  output logic                            out_en,
  input  logic                            outbusy,
  output logic [$clog2(DEPTH+1)-1:0]      fifo_level,
  output logic                            overflow
);
  localparam int KW   = $clog2(MAX_LOG2 + 1);
  localparam int ACCW = acc_width(DATA_WIDTH, MAX_LOG2);
  localparam int PW   = MAX_LOG2;
  localparam logic [KW-1:0] KMAX = KW'(MAX_LOG2);

  logic [PW-1:0]          r_phase;
  logic [KW-1:0]          r_k;
  logic                   r_mode;
  logic signed [ACCW-1:0] r_acc;
  logic                   r_stg_vld;
  logic [DATA_WIDTH-1:0]  r_stg;
  logic                   r_ovf;

  logic [KW-1:0]          w_kin, w_k;
  logic                   w_ph0, w_mode, w_term;
  logic [PW-1:0]          w_lastph;
  logic signed [ACCW-1:0] w_sx, w_sum, w_rnd;
  logic [DATA_WIDTH-1:0]  w_avg, w_res, w_head;
  logic                   w_full, w_empty;

  // Phase 0 uses the live k/mode, since that is the cycle they get latched.
  assign w_kin    = (ratio_log2 > KMAX) ? KMAX : ratio_log2;
  assign w_ph0    = (r_phase == '0);
  assign w_k      = w_ph0 ? w_kin : r_k;
  assign w_mode   = w_ph0 ? mode  : r_mode;
  assign w_lastph = ~({PW{1'b1}} << w_k);
  assign w_term   = in_valid && (r_phase == w_lastph);

  assign w_sx  = ACCW'($signed(dataIn));
  assign w_sum = w_ph0 ? w_sx : r_acc + w_sx;
`ifdef ADDA_DS_ROUND_EN
  assign w_rnd = (w_k == '0) ? '0 : (ACCW'(1) << (w_k - KW'(1)));
`else
  assign w_rnd = '0;
`endif
  assign w_avg = DATA_WIDTH'((w_sum + w_rnd) >>> w_k);
  assign w_res = (w_mode == MODE_AVG) ? w_avg
               : (w_ph0 ? dataIn : r_acc[DATA_WIDTH-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase   <= '0;
      r_k       <= '0;
      r_mode    <= MODE_PICK;
      r_acc     <= '0;
      r_stg_vld <= 1'b0;
      r_stg     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (in_valid) begin
        r_phase <= w_term ? '0 : r_phase + PW'(1);
        if (w_ph0) begin
          r_k    <= w_kin;
          r_mode <= mode;
        end
        // In pick mode the accumulator simply holds the phase-0 sample.
        r_acc <= (w_mode == MODE_AVG) ? w_sum : (w_ph0 ? w_sx : r_acc);
      end
      r_stg_vld <= w_term;
      if (w_term) r_stg <= DATA_WIDTH'(to_offset_bin(32'(w_res), DATA_WIDTH));
      r_ovf <= r_ovf | (r_stg_vld & w_full & ~out_en);
    end
  end

  adda_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_stg_vld),
    .pop   (out_en),
    .din   (r_stg),
    .dout  (w_head),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

  assign out_en    = !w_empty && !outbusy;
  assign dsoutdata = w_empty ? '0 : w_head;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_adda_decim_ob.sv
// Bench for adda_decim_ob: cycle table, directed corner sequences, random vs model.
module tb_adda_decim_ob;
  localparam int DW = 14;
  localparam int ML = 4;
  localparam int DEPTH = 4;
`ifdef ADDA_DS_ROUND_EN
  localparam logic [DW-1:0] RND_EXP = 14'h1FFF;
`else
  localparam logic [DW-1:0] RND_EXP = 14'h1FFE;
`endif

  logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, mode = 1'b0, outbusy = 1'b0;
  logic [DW-1:0] dataIn = '0;
  logic [2:0]    ratio_log2 = '0;
  logic [DW-1:0] dsoutdata;
  logic          out_en;
  logic [2:0]    fifo_level;
  logic          overflow;

  int n_vec = 0, n_err = 0;
  logic [DW-1:0] sb[$];
  bit mon_en = 0, mdl_en = 0;
  int m_cnt = 0, m_k = 0, m_first = 0;
  bit m_mode = 0;
  longint m_sum = 0;

  typedef struct {
    bit v; int d; int k; bit m; bit busy; bit en; logic [DW-1:0] q;
  } vec_t;
  vec_t tbl[27];

  adda_decim_ob #(.DATA_WIDTH(DW), .MAX_LOG2(ML), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .dataIn(dataIn),
    .ratio_log2(ratio_log2), .mode(mode), .dsoutdata(dsoutdata),
    .out_en(out_en), .outbusy(outbusy), .fifo_level(fifo_level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ob(longint v);
    return DW'(v + (longint'(1) << (DW - 1)));
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Block-level reference: gather 2^k samples, then pick the first or take the floored mean.
  task automatic model_in(int d, int k, bit md);
    longint a, b, q;
    if (m_cnt == 0) begin
      m_k = (k > ML) ? ML : k; m_mode = md; m_sum = 0; m_first = d;
    end
    m_sum += d;
    m_cnt++;
    if (m_cnt == (1 << m_k)) begin
      if (m_mode) begin
        b = longint'(1) << m_k;
        a = m_sum;
`ifdef ADDA_DS_ROUND_EN
        if (m_k > 0) a += b / 2;
`endif
        q = a / b;
        if ((a % b) != 0 && a < 0) q -= 1;
        sb.push_back(ob(q));
      end else begin
        sb.push_back(ob(m_first));
      end
      m_cnt = 0;
    end
  endtask

  task automatic step();
    #1;
    if (mon_en) begin
      if (out_en) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL out_en: got output 0x%0h, want no output", dsoutdata);
        end else chk("dsoutdata", dsoutdata, sb.pop_front());
      end else if (fifo_level == 0) chk("empty_data", dsoutdata, 0);
    end
    if (mdl_en && in_valid) model_in($signed(dataIn), int'(ratio_log2), mode);
    @(posedge clk); #1;
  endtask

  task automatic drain(string nm);
    in_valid = 0; outbusy = 0;
    for (int i = 0; i < 40 && (sb.size() != 0 || fifo_level != 0); i++) step();
    chk({nm, "_pending"}, sb.size(), 0);
    chk({nm, "_level"}, fifo_level, 0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, -8192, 0, 1'b0, 1'b0, 1'b0, 14'h0000};
    tbl[1]  = '{1'b1,     0, 0, 1'b0, 1'b0, 1'b0, 14'h0000};
    tbl[2]  = '{1'b1,  8191, 0, 1'b0, 1'b0, 1'b1, 14'h0000};
    tbl[3]  = '{1'b0,     0, 0, 1'b0, 1'b0, 1'b1, 14'h2000};
    tbl[4]  = '{1'b0,     0, 0, 1'b0, 1'b0, 1'b1, 14'h3FFF};
    tbl[5]  = '{1'b0,     0, 0, 1'b0, 1'b0, 1'b0, 14'h0000};
    tbl[6]  = '{1'b1,   100, 2, 1'b1, 1'b0, 1'b0, 14'h0000};
    tbl[7]  = '{1'b0,     0, 2, 1'b1, 1'b0, 1'b0, 14'h0000};
    tbl[8]  = '{1'b1,   200, 2, 1'b1, 1'b0, 1'b0, 14'h0000};
    tbl[9]  = '{1'b1,   300, 2, 1'b1, 1'b0, 1'b0, 14'h0000};
    tbl[10] = '{1'b0,     0, 2, 1'b1, 1'b0, 1'b0, 14'h0000};
    tbl[11] = '{1'b1,   400, 2, 1'b1, 1'b0, 1'b0, 14'h0000};
    tbl[12] = '{1'b0,     0, 2, 1'b1, 1'b0, 1'b0, 14'h0000};
    tbl[13] = '{1'b0,     0, 2, 1'b1, 1'b0, 1'b1, 14'h20FA};
    tbl[14] = '{1'b0,     0, 2, 1'b1, 1'b0, 1'b0, 14'h0000};
    tbl[15] = '{1'b1,    -1, 2, 1'b1, 1'b0, 1'b0, 14'h0000};
    tbl[16] = '{1'b1,    -1, 2, 1'b1, 1'b0, 1'b0, 14'h0000};
    tbl[17] = '{1'b1,    -1, 2, 1'b1, 1'b0, 1'b0, 14'h0000};
    tbl[18] = '{1'b1,    -2, 2, 1'b1, 1'b0, 1'b0, 14'h0000};
    tbl[19] = '{1'b0,     0, 2, 1'b1, 1'b0, 1'b0, 14'h0000};
    tbl[20] = '{1'b0,     0, 2, 1'b1, 1'b0, 1'b1, RND_EXP};
    tbl[21] = '{1'b0,     0, 2, 1'b1, 1'b0, 1'b0, 14'h0000};
    tbl[22] = '{1'b1,     5, 0, 1'b0, 1'b1, 1'b0, 14'h0000};
    tbl[23] = '{1'b0,     0, 0, 1'b0, 1'b1, 1'b0, 14'h0000};
    tbl[24] = '{1'b0,     0, 0, 1'b0, 1'b1, 1'b0, 14'h2005};
    tbl[25] = '{1'b0,     0, 0, 1'b0, 1'b0, 1'b1, 14'h2005};
    tbl[26] = '{1'b0,     0, 0, 1'b0, 1'b0, 1'b0, 14'h0000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", dsoutdata, 0);
    chk("rst_en", out_en, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    rst = 0;

    // Cycle table: pass-through, gapped average, rounding, busy hold
    for (int i = 0; i < 27; i++) begin
      in_valid = tbl[i].v; dataIn = DW'(tbl[i].d); ratio_log2 = 3'(tbl[i].k);
      mode = tbl[i].m; outbusy = tbl[i].busy;
      #1;
      chk($sformatf("tbl%0d_en", i), out_en, tbl[i].en);
      chk($sformatf("tbl%0d_data", i), dsoutdata, tbl[i].q);
      @(posedge clk); #1;
    end

    // Pick k=3, k changed to 1 mid-block applies from input 16
    mon_en = 1; mdl_en = 0; sb.delete();
    sb.push_back(14'h2000); sb.push_back(14'h2008);
    sb.push_back(14'h2010); sb.push_back(14'h2012);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; dataIn = DW'(i); mode = 0; ratio_log2 = (i < 12) ? 3'd3 : 3'd1;
      step();
    end
    drain("pick");

    // Overflow with DEPTH=4
    mon_en = 0; outbusy = 1; ratio_log2 = 0; mode = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; dataIn = DW'(i + 1);
      @(posedge clk); #1;
    end
    in_valid = 1; dataIn = DW'(6);
    #1;
    chk("ovf_level_full", fifo_level, 4);
    chk("ovf_not_yet", overflow, 0);
    chk("ovf_busy_en", out_en, 0);
    @(posedge clk); #1;
    in_valid = 0; outbusy = 0;
    #1;
    chk("ovf_set", overflow, 1);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_en", out_en, 1);
    chk("ovf_first", dsoutdata, ob(1));
    @(posedge clk); #1;
    chk("ovf_pushpop_level", fifo_level, 4);
    sb.delete();
    sb.push_back(ob(2)); sb.push_back(ob(3)); sb.push_back(ob(4)); sb.push_back(ob(6));
    mon_en = 1;
    drain("ovf");
    chk("ovf_sticky", overflow, 1);

    // Reset mid-block discards partial average
    mon_en = 0; ratio_log2 = 2; mode = 1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; dataIn = DW'(1000);
      @(posedge clk); #1;
    end
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("mrst_data", dsoutdata, 0);
    chk("mrst_en", out_en, 0);
    chk("mrst_level", fifo_level, 0);
    chk("mrst_ovf", overflow, 0);
    @(posedge clk); #1;
    rst = 0;
    sb.delete(); sb.push_back(ob(10)); mon_en = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; dataIn = DW'(4 * i);
      step();
    end
    drain("mrst");

    // Random stimulus against the block-level model
    sb.delete(); m_cnt = 0; mon_en = 1; mdl_en = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) ratio_log2 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) mode = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 9) < 6) && (sb.size() <= DEPTH - 2);
      dataIn = DW'($urandom);
      outbusy = ($urandom_range(0, 9) < 3);
      step();
    end
    drain("rand");
    chk("rand_ovf", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
